// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller sitting between the IF/ID and ID/EX stages.
// Holds the front end on load-use hazards, squashes wrong-path slots after
// a redirect, freezes everything while memory is busy, and keeps saturating
// stall/flush event counters.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_RUN     | normal flow; load-use hazards evaluated combinationally
// ST_LOAD_STL| front end held, bubble injected; rem cycles still to go
// ST_FLUSH   | IF/ID squashed on wrong-path slots; rem cycles still to go
module hazard_control_unit #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int CNT_W             = 16,
    parameter int ZERO_REG_BYPASS   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction,
    input  logic             fd_uses_rt,
    input  logic [4:0]       dx_rt,
    input  logic             dx_mem_read,
    input  logic             branch,
    input  logic             equals_result,
    input  logic             jump,
    input  logic             mem_busy,
    input  logic             counter_clear,
    output logic             pc_load_enable,
    output logic             fd_load_enable,
    output logic             dx_bubble,
    output logic             fd_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int REM_MAX = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ? LOAD_STALL_CYCLES : FLUSH_CYCLES;
    localparam int REM_W   = (REM_MAX > 1) ? $clog2(REM_MAX + 1) : 1;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   stall_q, flush_q;
    logic               stall_inc, flush_inc;
    logic               hz, redir, zero_bypass;
    logic [4:0]         rs, rt;
    logic               unused_instr_bits;

    assign rs = instruction[25:21];
    assign rt = instruction[20:16];
    assign unused_instr_bits = ^{instruction[31:26], instruction[15:0]};

    assign zero_bypass = (ZERO_REG_BYPASS != 0) && (dx_rt == 5'd0);
    assign hz    = dx_mem_read && ((dx_rt == rs) || (fd_uses_rt && (dx_rt == rt))) && !zero_bypass;
    assign redir = jump || (branch && equals_result);

    // Next-state, rem and same-cycle pipeline controls; priority mem_busy > redir > hz.
    always_comb begin
        state_d        = state_q;
        rem_d          = rem_q;
        pc_load_enable = 1'b1;
        fd_load_enable = 1'b1;
        dx_bubble      = 1'b0;
        fd_flush       = 1'b0;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;

        if (mem_busy) begin
            pc_load_enable = 1'b0;
            fd_load_enable = 1'b0;
        end else if (redir) begin
            fd_flush  = 1'b1;
            flush_inc = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = ST_FLUSH;
                rem_d   = REM_W'(FLUSH_CYCLES - 1);
            end else begin
                state_d = ST_RUN;
                rem_d   = '0;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hz) begin
                        pc_load_enable = 1'b0;
                        fd_load_enable = 1'b0;
                        dx_bubble      = 1'b1;
                        stall_inc      = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = ST_LOAD_STALL;
                            rem_d   = REM_W'(LOAD_STALL_CYCLES - 1);
                        end
                    end
                end
                ST_LOAD_STALL: begin
                    pc_load_enable = 1'b0;
                    fd_load_enable = 1'b0;
                    dx_bubble      = 1'b1;
                    stall_inc      = 1'b1;
                    if (rem_q == REM_W'(1)) begin
                        state_d = ST_RUN;
                        rem_d   = '0;
                    end else begin
                        rem_d = rem_q - REM_W'(1);
                    end
                end
                ST_FLUSH: begin
                    fd_flush = 1'b1;
                    if (rem_q == REM_W'(1)) begin
                        state_d = ST_RUN;
                        rem_d   = '0;
                    end else begin
                        rem_d = rem_q - REM_W'(1);
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    rem_d   = '0;
                end
            endcase
        end

        // Reset overrides the combinational hazard path so the pipe runs free.
        if (rst) begin
            pc_load_enable = 1'b1;
            fd_load_enable = 1'b1;
            dx_bubble      = 1'b0;
            fd_flush       = 1'b0;
        end
    end

    // FSM state and remaining-cycle down-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Saturating event counters; clear beats a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (counter_clear) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_inc && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_inc && (flush_q != {CNT_W{1'b1}})) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: three instances with different
// parameter sets share one stimulus stream; each directed step pushes the
// expected controls/counters for one instance, a negedge monitor compares.
module tb_hazard_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = '0;
    logic        fd_uses_rt = 1'b0;
    logic [4:0]  dx_rt = '0;
    logic        dx_mem_read = 1'b0;
    logic        branch = 1'b0;
    logic        equals_result = 1'b0;
    logic        jump = 1'b0;
    logic        mem_busy = 1'b0;
    logic        counter_clear = 1'b0;

    logic        pc_a, fd_a, bub_a, fl_a;
    logic        pc_b, fd_b, bub_b, fl_b;
    logic        pc_c, fd_c, bub_c, fl_c;
    logic [15:0] sc_a, fe_a, sc_b, fe_b;
    logic [1:0]  sc_c, fe_c;

    logic [3:0]  ctl_o [3];
    logic [15:0] sc_o  [3];
    logic [15:0] fe_o  [3];

    assign ctl_o[0] = {pc_a, fd_a, bub_a, fl_a};
    assign ctl_o[1] = {pc_b, fd_b, bub_b, fl_b};
    assign ctl_o[2] = {pc_c, fd_c, bub_c, fl_c};
    assign sc_o[0] = sc_a;
    assign sc_o[1] = sc_b;
    assign sc_o[2] = {14'd0, sc_c};
    assign fe_o[0] = fe_a;
    assign fe_o[1] = fe_b;
    assign fe_o[2] = {14'd0, fe_c};

    // inst 0: LSC=1 FC=1 zero bypass on
    hazard_control_unit #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(16), .ZERO_REG_BYPASS(1)) u_a (
        .clk(clk), .rst(rst), .instruction(instruction), .fd_uses_rt(fd_uses_rt),
        .dx_rt(dx_rt), .dx_mem_read(dx_mem_read), .branch(branch), .equals_result(equals_result),
        .jump(jump), .mem_busy(mem_busy), .counter_clear(counter_clear),
        .pc_load_enable(pc_a), .fd_load_enable(fd_a), .dx_bubble(bub_a), .fd_flush(fl_a),
        .stall_cycles(sc_a), .flush_events(fe_a));

    // inst 1: LSC=3 FC=2 zero bypass off
    hazard_control_unit #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(16), .ZERO_REG_BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .instruction(instruction), .fd_uses_rt(fd_uses_rt),
        .dx_rt(dx_rt), .dx_mem_read(dx_mem_read), .branch(branch), .equals_result(equals_result),
        .jump(jump), .mem_busy(mem_busy), .counter_clear(counter_clear),
        .pc_load_enable(pc_b), .fd_load_enable(fd_b), .dx_bubble(bub_b), .fd_flush(fl_b),
        .stall_cycles(sc_b), .flush_events(fe_b));

    // inst 2: 2-bit counters
    hazard_control_unit #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(2), .ZERO_REG_BYPASS(1)) u_c (
        .clk(clk), .rst(rst), .instruction(instruction), .fd_uses_rt(fd_uses_rt),
        .dx_rt(dx_rt), .dx_mem_read(dx_mem_read), .branch(branch), .equals_result(equals_result),
        .jump(jump), .mem_busy(mem_busy), .counter_clear(counter_clear),
        .pc_load_enable(pc_c), .fd_load_enable(fd_c), .dx_bubble(bub_c), .fd_flush(fl_c),
        .stall_cycles(sc_c), .flush_events(fe_c));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         inst;
        logic [3:0] ctl;   // {pc_le, fd_le, bubble, flush}
        int         sc;
        int         fe;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;

    // Monitor: compare every expectation that belongs to the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            total++;
            if (mon_e.cyc < cyc) begin
                bad++;
                $display("FAIL %s stale entry for cycle %0d seen at cycle %0d", mon_e.name, mon_e.cyc, cyc);
            end else if (ctl_o[mon_e.inst] !== mon_e.ctl ||
                         sc_o[mon_e.inst] !== 16'(mon_e.sc) ||
                         fe_o[mon_e.inst] !== 16'(mon_e.fe)) begin
                bad++;
                $display("FAIL %s inst=%0d got ctl=%b stall=%0d flush=%0d want ctl=%b stall=%0d flush=%0d",
                         mon_e.name, mon_e.inst, ctl_o[mon_e.inst], sc_o[mon_e.inst], fe_o[mon_e.inst],
                         mon_e.ctl, mon_e.sc, mon_e.fe);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(int inst, logic [3:0] ctl, int sc, int fe, string nm);
        exp_t e;
        e.cyc = cyc; e.inst = inst; e.ctl = ctl; e.sc = sc; e.fe = fe; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic idle();
        instruction = '0; fd_uses_rt = 0; dx_rt = '0; dx_mem_read = 0;
        branch = 0; equals_result = 0; jump = 0; mem_busy = 0; counter_clear = 0;
    endtask

    task automatic load_hz(logic [4:0] rs, logic [4:0] rt, logic [4:0] drt, logic uses_rt);
        instruction = {6'd0, rs, rt, 16'd0};
        dx_rt = drt; fd_uses_rt = uses_rt; dx_mem_read = 1'b1;
    endtask

    task automatic reset_all();
        tick(); rst = 1'b1; idle();
        tick(); rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        // reset with a live hazard on the inputs: outputs must be forced free
        load_hz(5'd8, 5'd0, 5'd8, 1'b0);
        tick();
        push_exp(0, 4'b1100, 0, 0, "rst_forced_a");
        push_exp(1, 4'b1100, 0, 0, "rst_forced_b");
        tick(); rst = 1'b0; idle();
        push_exp(0, 4'b1100, 0, 0, "idle_a");

        // single-cycle load-use stall on rs
        tick(); load_hz(5'd8, 5'd0, 5'd8, 1'b0);
        push_exp(0, 4'b0010, 0, 0, "t1_stall");
        tick(); idle();
        push_exp(0, 4'b1100, 1, 0, "t1_release");

        // three-cycle stall on rt; hz not re-evaluated once stalled
        reset_all();
        tick(); load_hz(5'd3, 5'd9, 5'd9, 1'b1);
        push_exp(1, 4'b0010, 0, 0, "t2_rt_hz");
        tick(); idle();
        push_exp(1, 4'b0010, 1, 0, "t2_hold1");
        tick();
        push_exp(1, 4'b0010, 2, 0, "t2_hold2");
        tick();
        push_exp(1, 4'b1100, 3, 0, "t2_done");
        tick(); load_hz(5'd3, 5'd9, 5'd9, 1'b0);
        push_exp(1, 4'b1100, 3, 0, "t2_rt_unused");
        tick(); idle();

        // r0 destination: bypassed in inst 0, stalls in inst 1
        reset_all();
        tick(); load_hz(5'd0, 5'd0, 5'd0, 1'b0);
        push_exp(0, 4'b1100, 0, 0, "t3_bypass");
        push_exp(1, 4'b0010, 0, 0, "t3_no_bypass");
        tick(); idle();

        // taken branch aborts a load stall, two flush slots
        reset_all();
        tick(); load_hz(5'd8, 5'd0, 5'd8, 1'b0);
        push_exp(1, 4'b0010, 0, 0, "t4_stall");
        tick(); idle(); branch = 1; equals_result = 1;
        push_exp(1, 4'b1101, 1, 0, "t4_redir");
        tick(); idle();
        push_exp(1, 4'b1101, 1, 1, "t4_flush2");
        tick();
        push_exp(1, 4'b1100, 1, 1, "t4_run");
        tick(); branch = 1;
        push_exp(1, 4'b1100, 1, 1, "t4_not_taken");
        tick(); idle();

        // memory busy freezes a stall in progress
        reset_all();
        tick(); load_hz(5'd8, 5'd0, 5'd8, 1'b0);
        push_exp(1, 4'b0010, 0, 0, "t5_stall");
        tick(); idle(); mem_busy = 1;
        push_exp(1, 4'b0000, 1, 0, "t5_busy0");
        for (int i = 0; i < 3; i++) begin
            tick();
            push_exp(1, 4'b0000, 1, 0, "t5_busy");
        end
        tick(); mem_busy = 0;
        push_exp(1, 4'b0010, 1, 0, "t5_resume1");
        tick();
        push_exp(1, 4'b0010, 2, 0, "t5_resume2");
        tick();
        push_exp(1, 4'b1100, 3, 0, "t5_done");

        // 2-bit flush counter saturation, clear vs jump, reset mid-flush
        reset_all();
        for (int i = 0; i < 5; i++) begin
            tick(); idle(); jump = 1;
            push_exp(2, 4'b1101, 0, (i < 3) ? i : 3, "t6_jump");
        end
        tick(); jump = 1; counter_clear = 1;
        push_exp(2, 4'b1101, 0, 3, "t6_clr_jump");
        tick(); counter_clear = 0; jump = 1;
        push_exp(2, 4'b1101, 0, 0, "t6_cleared");
        push_exp(1, 4'b1101, 0, 0, "t6_b_flush");
        tick(); jump = 0; rst = 1'b1;
        push_exp(1, 4'b1100, 0, 0, "t6_rst_mid_flush");
        push_exp(2, 4'b1100, 0, 0, "t6_rst_c");
        tick(); rst = 1'b0; idle();

        repeat (3) tick();
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
